daa_feeder: RTL and testbench
=============================

DAA_FEEDER -- requirements
Module: daa_feeder

Interface
REQ-001 SHALL have parameter MAX_EP, default 9, meaning the maximum number of elementary products per dot product (1..9).
REQ-002 SHALL have parameter FLUSH_CYC, default 2, meaning the number of drain cycles after the last digit (1..7).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a dot product.
REQ-006 SHALL have port len, input, 4, the element count, sampled with start.
REQ-007 SHALL have port in_valid, input, 1, meaning act/wgt carry a valid element.
REQ-008 SHALL have port in_ready, output, 1, meaning the feeder accepts an element this cycle.
REQ-009 SHALL have port act, input, 4, the activation nibble (two's complement).
REQ-010 SHALL have port wgt, input, 8, the weight (two's complement).
REQ-011 SHALL have port inpe, output, 4, the activation presented to the DAA MAC.
REQ-012 SHALL have port w, output, 3, the radix-4 Booth triplet presented to the MAC.
REQ-013 SHALL have port nep, output, 1, the new-elementary-product strobe.
REQ-014 SHALL have port epcount, output, 4, the current element index.
REQ-015 SHALL have port pe_en, output, 1, the MAC enable.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, SHIFT, FLUSH, DONE; all outputs driven from registers.
REQ-019 SHALL, in IDLE, on start=1 with len!=0, latch n=min(len,MAX_EP), clear elem to 0, and enter WAIT on the next edge.
REQ-020 SHALL ignore start when len=0 (remain IDLE, no done pulse), and SHALL ignore start in every state other than IDLE.
REQ-021 SHALL, in WAIT, drive in_ready=1 and pe_en=0; on in_valid=1, latch act/wgt, set digit=0, and enter SHIFT.
REQ-022 SHALL, in SHIFT, hold pe_en=1 for exactly 4 cycles (digit 0..3), presenting inpe=latched act, and w={wgt[1],wgt[0],0}, {wgt[3:1]}, {wgt[5:3]}, {wgt[7:5]} for digits 0..3 respectively.
REQ-023 SHALL drive nep=1 only during digit 3 of SHIFT, and SHALL drive epcount=elem throughout SHIFT.
REQ-024 SHALL, in digit 3, drive in_ready=1 when elem<n-1; acceptance there SHALL enter digit 0 of the next element on the next edge with no bubble (elem+1).
REQ-025 SHALL, after digit 3 without acceptance, go to WAIT if elem<n-1 (elem incremented), else enter FLUSH.
REQ-026 SHALL, in FLUSH, hold pe_en=1, w=000, nep=0, and inpe/epcount unchanged for exactly FLUSH_CYC cycles, then enter DONE.
REQ-027 SHALL, in DONE, drive done=1 for one cycle with pe_en=0, then return to IDLE.
REQ-028 SHALL drive in_ready=0 in IDLE, FLUSH, DONE, and in SHIFT digits 0..2; in_valid in those cycles SHALL be ignored.
REQ-029 SHALL keep epcount in 0..8; elem SHALL never wrap.
REQ-030 SHALL hold the latched act/wgt stable between acceptances.

Reset
REQ-031 SHALL, on rst=0, enter IDLE immediately (asynchronously) and drive inpe=0, w=000, nep=0, epcount=0, pe_en=0, in_ready=0, busy=0, done=0, including mid-SHIFT or mid-FLUSH.
REQ-032 SHALL, after rst returns high, require a new start; no partial dot product resumes.

Verification
REQ-033 SHALL be verified by: start, len=1, act=0x5, wgt=0x2D -> w=010,110,101,001 on 4 consecutive pe_en cycles, nep only on 4th, then 2 flush cycles with w=000, then done=1 once.
REQ-034 SHALL be verified by: len=3 with in_valid held high -> 12 back-to-back SHIFT cycles, epcount 0,0,0,0,1,...,2, nep on cycles 4,8,12, in_ready on cycles 4 and 8 plus initial WAIT only.
REQ-035 SHALL be verified by: len=2, in_valid low 5 cycles after the first element -> WAIT with pe_en=0 for 5 cycles, epcount=1 on resume.
REQ-036 SHALL be verified by: len=12 -> exactly 9 elements consumed, last epcount=8; and len=0 -> no busy, no done.
REQ-037 SHALL be verified by: rst=0 asserted during SHIFT digit 2 -> all outputs 0 before the next clk edge; start while busy -> no effect.

Source files
------------

// File: rtl/daa_feeder_if.sv
// daa_feeder_if: element stream handshake (act/wgt with valid/ready) into the DAA feeder
interface daa_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] act;
  logic [7:0] wgt;
  modport master (output in_valid, act, wgt, input in_ready);
  modport slave  (input in_valid, act, wgt, output in_ready);
endinterface

// File: rtl/daa_feeder.sv
// daa_feeder: sequences act/wgt elements into radix-4 Booth digits, flush and done for a DAA MAC
module daa_feeder #(
  parameter int MAX_EP    = 9,
  parameter int FLUSH_CYC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   len,
  daa_feeder_if.slave  in_if,
  output logic [3:0]   inpe,
  output logic [2:0]   w,
  output logic         nep,
  output logic [3:0]   epcount,
  output logic         pe_en,
  output logic         busy,
  output logic         done
);
  typedef enum logic [2:0] {IDLE, WAIT, SHIFT, FLUSH, DONE} state_t;
  localparam logic [3:0] MAX_N   = 4'(MAX_EP);
  localparam logic [2:0] FL_LAST = 3'(FLUSH_CYC - 1);
  state_t     state_q, state_d;
  logic [3:0] n_q, n_d, elem_q, elem_d, act_q, act_d;
  logic [7:0] wgt_q, wgt_d;
  logic [1:0] digit_q, digit_d;
  logic [2:0] flush_q, flush_d;
  logic       in_ready_q, in_ready_d, nep_q, nep_d, pe_en_q, pe_en_d, busy_q, busy_d, done_q, done_d;
  logic [3:0] inpe_q, inpe_d, epcount_q, epcount_d;
  logic [2:0] w_q, w_d;
  logic       take, last;
  always_comb begin
    take    = in_if.in_valid && in_ready_q;
    last    = elem_q + 4'd1 >= n_q;
    state_d = state_q;
    n_d     = n_q;
    elem_d  = elem_q;
    act_d   = act_q;
    wgt_d   = wgt_q;
    digit_d = digit_q;
    flush_d = flush_q;
    case (state_q)
      IDLE: if (start && len != 4'd0) begin
        state_d = WAIT;
        n_d     = len > MAX_N ? MAX_N : len;
        elem_d  = 4'd0;
      end
      WAIT: if (take) begin
        state_d = SHIFT;
        digit_d = 2'd0;
        act_d   = in_if.act;
        wgt_d   = in_if.wgt;
      end
      SHIFT: if (digit_q != 2'd3) begin
        digit_d = digit_q + 2'd1;
      end else if (take) begin
        elem_d  = elem_q + 4'd1;
        digit_d = 2'd0;
        act_d   = in_if.act;
        wgt_d   = in_if.wgt;
      end else if (!last) begin
        elem_d  = elem_q + 4'd1;
        state_d = WAIT;
      end else begin
        state_d = FLUSH;
        flush_d = 3'd0;
      end
      FLUSH: begin
        flush_d = flush_q + 3'd1;
        state_d = flush_q == FL_LAST ? DONE : FLUSH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs are decoded from the next state so every port comes straight from a flop
    in_ready_d = state_d == WAIT || (state_d == SHIFT && digit_d == 2'd3 && elem_d + 4'd1 < n_d);
    pe_en_d    = state_d == SHIFT || state_d == FLUSH;
    inpe_d     = pe_en_d ? act_d : 4'd0;
    epcount_d  = (state_d == IDLE || state_d == DONE) ? 4'd0 : elem_d;
    nep_d      = state_d == SHIFT && digit_d == 2'd3;
    w_d        = state_d != SHIFT  ? 3'd0 :
                 digit_d == 2'd0   ? {wgt_d[1:0], 1'b0} :
                 digit_d == 2'd1   ? wgt_d[3:1] :
                 digit_d == 2'd2   ? wgt_d[5:3] : wgt_d[7:5];
    busy_d     = state_d != IDLE;
    done_d     = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      elem_q     <= '0;
      act_q      <= '0;
      wgt_q      <= '0;
      digit_q    <= '0;
      flush_q    <= '0;
      in_ready_q <= 1'b0;
      nep_q      <= 1'b0;
      pe_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inpe_q     <= '0;
      epcount_q  <= '0;
      w_q        <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      elem_q     <= elem_d;
      act_q      <= act_d;
      wgt_q      <= wgt_d;
      digit_q    <= digit_d;
      flush_q    <= flush_d;
      in_ready_q <= in_ready_d;
      nep_q      <= nep_d;
      pe_en_q    <= pe_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      inpe_q     <= inpe_d;
      epcount_q  <= epcount_d;
      w_q        <= w_d;
    end
  end
  assign in_if.in_ready = in_ready_q;
  assign inpe           = inpe_q;
  assign w              = w_q;
  assign nep            = nep_q;
  assign epcount        = epcount_q;
  assign pe_en          = pe_en_q;
  assign busy           = busy_q;
  assign done           = done_q;
endmodule

// File: tb/tb_daa_feeder.sv
// tb_daa_feeder: directed scenario checks of the DAA feeder against hand-computed output vectors
module tb_daa_feeder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] len = 4'd0;
  logic [3:0] inpe, epcount;
  logic [2:0] w;
  logic       nep, pe_en, busy, done;
  logic [15:0] obs;
  int checks = 0;
  int failures = 0;
  daa_feeder_if bus();
  daa_feeder #(.MAX_EP(9), .FLUSH_CYC(2)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_if(bus),
    .inpe(inpe), .w(w), .nep(nep), .epcount(epcount),
    .pe_en(pe_en), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  // {busy, done, pe_en, in_ready, nep, w, epcount, inpe}
  assign obs = {busy, done, pe_en, bus.in_ready, nep, w, epcount, inpe};
  function automatic logic [15:0] v(bit b, bit d, bit p, bit r, bit n, logic [2:0] ww, logic [3:0] e, logic [3:0] i);
    return {b, d, p, r, n, ww, e, i};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.in_valid = 1'b0; bus.act = 4'd0; bus.wgt = 8'd0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs !== 16'd0) begin failures++; $display("FAIL reset got=%b exp=%b", obs, 16'd0); end
    @(negedge clk) rst = 1'b1;
    step();
    checks++;
    if (obs !== 16'd0) begin failures++; $display("FAIL reset_idle got=%b exp=%b", obs, 16'd0); end
  endtask
  task automatic test_single();
    logic [15:0] exp [9];
    exp = '{v(1,0,0,1,0,3'b000,0,0), v(1,0,1,0,0,3'b010,0,5), v(1,0,1,0,0,3'b110,0,5),
            v(1,0,1,0,0,3'b101,0,5), v(1,0,1,0,1,3'b001,0,5), v(1,0,1,0,0,3'b000,0,5),
            v(1,0,1,0,0,3'b000,0,5), v(1,1,0,0,0,3'b000,0,0), 16'd0};
    start = 1'b1; len = 4'd1; bus.in_valid = 1'b1; bus.act = 4'h5; bus.wgt = 8'h2D;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (obs !== exp[i]) begin failures++; $display("FAIL single[%0d] got=%b exp=%b", i, obs, exp[i]); end
      if (i == 0) start = 1'b0;
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic test_back_to_back();
    logic [15:0] exp [17];
    exp = '{v(1,0,0,1,0,3'b000,0,0),
            v(1,0,1,0,0,3'b100,0,3), v(1,0,1,0,0,3'b101,0,3), v(1,0,1,0,0,3'b011,0,3), v(1,0,1,1,1,3'b010,0,3),
            v(1,0,1,0,0,3'b110,1,12), v(1,0,1,0,0,3'b001,1,12), v(1,0,1,0,0,3'b110,1,12), v(1,0,1,1,1,3'b101,1,12),
            v(1,0,1,0,0,3'b100,2,7), v(1,0,1,0,0,3'b111,2,7), v(1,0,1,0,0,3'b001,2,7), v(1,0,1,0,1,3'b010,2,7),
            v(1,0,1,0,0,3'b000,2,7), v(1,0,1,0,0,3'b000,2,7), v(1,1,0,0,0,3'b000,0,0), 16'd0};
    start = 1'b1; len = 4'd3; bus.in_valid = 1'b1; bus.act = 4'h3; bus.wgt = 8'h5A;
    for (int i = 0; i < 17; i++) begin
      step();
      checks++;
      if (obs !== exp[i]) begin failures++; $display("FAIL b2b[%0d] got=%b exp=%b", i, obs, exp[i]); end
      if (i == 0) start = 1'b0;
      if (i == 1) begin bus.act = 4'hC; bus.wgt = 8'hB3; end
      if (i == 5) begin bus.act = 4'h7; bus.wgt = 8'h4E; end
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic test_wait_stall();
    logic [15:0] exp [18];
    exp = '{v(1,0,0,1,0,3'b000,0,0),
            v(1,0,1,0,0,3'b010,0,1), v(1,0,1,0,0,3'b000,0,1), v(1,0,1,0,0,3'b000,0,1), v(1,0,1,1,1,3'b000,0,1),
            v(1,0,0,1,0,3'b000,1,0), v(1,0,0,1,0,3'b000,1,0), v(1,0,0,1,0,3'b000,1,0),
            v(1,0,0,1,0,3'b000,1,0), v(1,0,0,1,0,3'b000,1,0),
            v(1,0,1,0,0,3'b110,1,2), v(1,0,1,0,0,3'b111,1,2), v(1,0,1,0,0,3'b111,1,2), v(1,0,1,0,1,3'b111,1,2),
            v(1,0,1,0,0,3'b000,1,2), v(1,0,1,0,0,3'b000,1,2), v(1,1,0,0,0,3'b000,0,0), 16'd0};
    start = 1'b1; len = 4'd2; bus.in_valid = 1'b1; bus.act = 4'h1; bus.wgt = 8'h01;
    for (int i = 0; i < 18; i++) begin
      step();
      checks++;
      if (obs !== exp[i]) begin failures++; $display("FAIL stall[%0d] got=%b exp=%b", i, obs, exp[i]); end
      if (i == 0) start = 1'b0;
      if (i == 1) bus.in_valid = 1'b0;
      if (i == 9) begin bus.in_valid = 1'b1; bus.act = 4'h2; bus.wgt = 8'hFF; end
      if (i == 10) bus.in_valid = 1'b0;
    end
  endtask
  task automatic test_len_clamp();
    int neps = 0, takes = 0, dones = 0;
    logic [3:0] last_ep = 4'hF;
    start = 1'b1; len = 4'd12; bus.in_valid = 1'b1; bus.act = 4'h9; bus.wgt = 8'h66;
    for (int i = 0; i < 60; i++) begin
      if (bus.in_ready && bus.in_valid) takes++;
      step();
      start = 1'b0;
      if (nep) begin neps++; last_ep = epcount; end
      if (done) dones++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (neps !== 9) begin failures++; $display("FAIL clamp_nep got=%0d exp=9", neps); end
    checks++;
    if (takes !== 9) begin failures++; $display("FAIL clamp_takes got=%0d exp=9", takes); end
    checks++;
    if (last_ep !== 4'd8) begin failures++; $display("FAIL clamp_last_ep got=%0d exp=8", last_ep); end
    checks++;
    if (dones !== 1) begin failures++; $display("FAIL clamp_done got=%0d exp=1", dones); end
    checks++;
    if (obs !== 16'd0) begin failures++; $display("FAIL clamp_idle got=%b exp=%b", obs, 16'd0); end
  endtask
  task automatic test_len_zero();
    start = 1'b1; len = 4'd0; bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({busy, done} !== 2'b00) begin failures++; $display("FAIL len0[%0d] busy_done got=%b exp=00", i, {busy, done}); end
    end
    start = 1'b0; bus.in_valid = 1'b0;
  endtask
  task automatic test_async_reset();
    start = 1'b1; len = 4'd2; bus.in_valid = 1'b1; bus.act = 4'hA; bus.wgt = 8'h2D;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (obs !== v(1,0,1,0,0,3'b101,0,10)) begin failures++; $display("FAIL arst_pre got=%b exp=%b", obs, v(1,0,1,0,0,3'b101,0,10)); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obs !== 16'd0) begin failures++; $display("FAIL arst_now got=%b exp=%b", obs, 16'd0); end
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs !== 16'd0) begin failures++; $display("FAIL arst_noresume[%0d] got=%b exp=%b", i, obs, 16'd0); end
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic test_start_busy();
    logic [15:0] exp [10];
    exp = '{v(1,0,0,1,0,3'b000,0,0), v(1,0,0,1,0,3'b000,0,0),
            v(1,0,1,0,0,3'b110,0,4), v(1,0,1,0,0,3'b111,0,4), v(1,0,1,0,0,3'b001,0,4), v(1,0,1,0,1,3'b000,0,4),
            v(1,0,1,0,0,3'b000,0,4), v(1,0,1,0,0,3'b000,0,4), v(1,1,0,0,0,3'b000,0,0), 16'd0};
    start = 1'b1; len = 4'd1; bus.in_valid = 1'b0; bus.act = 4'h4; bus.wgt = 8'h0F;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (obs !== exp[i]) begin failures++; $display("FAIL busy_start[%0d] got=%b exp=%b", i, obs, exp[i]); end
      if (i == 0) len = 4'd5;
      if (i == 1) bus.in_valid = 1'b1;
      if (i == 3) bus.in_valid = 1'b0;
      if (i == 6) start = 1'b0;
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wait_stall();
    test_len_clamp();
    test_len_zero();
    test_async_reset();
    test_start_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
